// File: rtl/alu_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl_if
//   Bundles every signal of alu_issue_ctrl except clock and reset:
//   the per-requester request bus, the control/operand bus to the shared
//   ALU (plus its combinational result), and the response handshake.
//   slave  : the issue controller's view.
//   master : the environment's view (requesters, external ALU, consumer).
// ---------------------------------------------------------------------------
interface alu_issue_ctrl_if #(
    parameter int XLEN    = 32,
    parameter int NUM_REQ = 2,
    parameter int IDW     = $clog2(NUM_REQ)
) ();
    // Requests; requester k occupies slice k of every vector.
    logic [NUM_REQ-1:0]      i_req_valid;
    logic [NUM_REQ-1:0]      o_req_ready;
    logic [3*NUM_REQ-1:0]    i_req_funct3;
    logic [NUM_REQ-1:0]      i_req_funct7b5;
    logic [NUM_REQ-1:0]      i_req_is_imm;
    logic [XLEN*NUM_REQ-1:0] i_req_op_a;
    logic [XLEN*NUM_REQ-1:0] i_req_op_b;

    // Shared ALU controls and its combinational result.
    logic [XLEN-1:0]         o_alu_op_a;
    logic [XLEN-1:0]         o_alu_op_b;
    logic                    o_alu_sub;
    logic [1:0]              o_alu_bool_op;
    logic [3:0]              o_alu_op_sel;
    logic                    o_alu_shift_dir;
    logic                    o_alu_cmp_sig;
    logic [XLEN-1:0]         i_alu_result;

    // One-entry response buffer.
    logic                    o_rsp_valid;
    logic                    i_rsp_ready;
    logic [XLEN-1:0]         o_rsp_data;
    logic [IDW-1:0]          o_rsp_id;

    modport slave (
        input  i_req_valid, i_req_funct3, i_req_funct7b5, i_req_is_imm,
               i_req_op_a, i_req_op_b, i_alu_result, i_rsp_ready,
        output o_req_ready, o_alu_op_a, o_alu_op_b, o_alu_sub, o_alu_bool_op,
               o_alu_op_sel, o_alu_shift_dir, o_alu_cmp_sig,
               o_rsp_valid, o_rsp_data, o_rsp_id
    );

    modport master (
        output i_req_valid, i_req_funct3, i_req_funct7b5, i_req_is_imm,
               i_req_op_a, i_req_op_b, i_alu_result, i_rsp_ready,
        input  o_req_ready, o_alu_op_a, o_alu_op_b, o_alu_sub, o_alu_bool_op,
               o_alu_op_sel, o_alu_shift_dir, o_alu_cmp_sig,
               o_rsp_valid, o_rsp_data, o_rsp_id
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//   Shares one external combinational 32-bit ALU between NUM_REQ requesters.
//   A round-robin arbiter picks one valid requester whenever the one-entry
//   response buffer can take a result, the granted RV32I funct3/funct7[5]
//   is decoded into ALU controls, and the ALU result is captured into the
//   buffer, which is drained with a valid/ready handshake.
// Ports
//   i_clk   : clock, all state on the rising edge
//   i_rst_n : synchronous active-low reset
//   bus     : alu_issue_ctrl_if.slave (requests, ALU controls/result,
//             response handshake)
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int XLEN    = 32,
    parameter int NUM_REQ = 2,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    alu_issue_ctrl_if.slave  bus
);

    typedef enum logic { EMPTY = 1'b0, FULL = 1'b1 } buf_state_e;

    buf_state_e      state, state_next;
    logic [IDW-1:0]  ptr, ptr_next;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_found;
    logic            can_issue;
    logic [XLEN-1:0] rsp_data;
    logic [IDW-1:0]  rsp_id;

    // Granted request fields.
    logic [2:0]      sel_funct3;
    logic            sel_funct7b5;
    logic            sel_is_imm;
    logic [XLEN-1:0] sel_op_a;
    logic [XLEN-1:0] sel_op_b;

    // A new result may be captured when the buffer is empty or is being
    // drained on this same edge. Reset suppresses every grant.
    assign can_issue = i_rst_n && ((state == EMPTY) || bus.i_rsp_ready);

    // Round-robin search starting at ptr; first valid requester wins.
    always_comb begin
        int slot;
        // NOTE: every variable written here gets a default first, so no
        // path through the block leaves a value held (no latch inferred).
        gnt_found       = 1'b0;
        gnt_idx         = '0;
        slot            = 0;
        bus.o_req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            slot = int'(ptr) + i;
            if (slot >= NUM_REQ) slot = slot - NUM_REQ;
            if (can_issue && !gnt_found && bus.i_req_valid[slot]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(slot);
            end
        end
        if (gnt_found) bus.o_req_ready[gnt_idx] = 1'b1;
        ptr_next = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end

    // Mux out the granted request.
    always_comb begin
        sel_funct3   = bus.i_req_funct3[3*gnt_idx +: 3];
        sel_funct7b5 = bus.i_req_funct7b5[gnt_idx];
        sel_is_imm   = bus.i_req_is_imm[gnt_idx];
        sel_op_a     = bus.i_req_op_a[XLEN*gnt_idx +: XLEN];
        sel_op_b     = bus.i_req_op_b[XLEN*gnt_idx +: XLEN];
    end

    // Decode to ALU controls. Everything stays zero without a grant so the
    // ALU idles at a result of 0.
    always_comb begin
        bus.o_alu_op_a      = '0;
        bus.o_alu_op_b      = '0;
        bus.o_alu_sub       = 1'b0;
        bus.o_alu_bool_op   = 2'b00;
        bus.o_alu_op_sel    = 4'b0000;
        bus.o_alu_shift_dir = 1'b0;
        bus.o_alu_cmp_sig   = 1'b0;
        if (gnt_found) begin
            bus.o_alu_op_a = sel_op_a;
            bus.o_alu_op_b = sel_op_b;
            unique case (sel_funct3)
                3'b000: begin
                    bus.o_alu_op_sel = 4'b0001;
                    // OP-IMM has no SUBI: bit 30 is immediate data there.
                    bus.o_alu_sub    = sel_funct7b5 & ~sel_is_imm;
                end
                3'b001: begin
                    bus.o_alu_op_sel = 4'b1000;
                    bus.o_alu_op_b   = {{(XLEN-5){1'b0}}, sel_op_b[4:0]};
                end
                3'b010: begin
                    bus.o_alu_op_sel  = 4'b0010;
                    bus.o_alu_sub     = 1'b1;
                    bus.o_alu_cmp_sig = 1'b1;
                end
                3'b011: begin
                    bus.o_alu_op_sel = 4'b0010;
                    bus.o_alu_sub    = 1'b1;
                end
                3'b100: begin
                    bus.o_alu_op_sel  = 4'b0100;
                    bus.o_alu_bool_op = 2'b00;
                end
                3'b101: begin
                    // SRAI keeps bit 30 as the arithmetic flag, unlike ADDI.
                    bus.o_alu_op_sel    = 4'b1000;
                    bus.o_alu_shift_dir = 1'b1;
                    bus.o_alu_sub       = sel_funct7b5;
                    bus.o_alu_op_b      = {{(XLEN-5){1'b0}}, sel_op_b[4:0]};
                end
                3'b110: begin
                    bus.o_alu_op_sel  = 4'b0100;
                    bus.o_alu_bool_op = 2'b10;
                end
                default: begin
                    bus.o_alu_op_sel  = 4'b0100;
                    bus.o_alu_bool_op = 2'b11;
                end
            endcase
        end
    end

    // Buffer FSM: next state and outputs.
    always_comb begin
        state_next      = state;
        bus.o_rsp_valid = (state == FULL);
        unique case (state)
            EMPTY: if (gnt_found) state_next = FULL;
            FULL: begin
                // Drain and reload on the same edge keeps the buffer full.
                if (gnt_found)             state_next = FULL;
                else if (bus.i_rsp_ready)  state_next = EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            // NOTE: the buffer payload is reset too; it is a handful of
            // flops, not a memory, and its reset value is observable.
            state    <= EMPTY;
            ptr      <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
        end else begin
            state <= state_next;
            if (gnt_found) begin
                rsp_data <= bus.i_alu_result;
                rsp_id   <= gnt_idx;
                ptr      <= ptr_next;
            end
        end
    end

    assign bus.o_rsp_data = rsp_data;
    assign bus.o_rsp_id   = rsp_id;

endmodule
